// File: rtl/gray_ptr_decoder_pkg.sv
// Shared types for the Gray pointer decoder.
// Sample classification used by the pending-count logic.
package gray_ptr_decoder_pkg;

   typedef enum logic [1:0] {
      STEP_NONE,
      STEP_ACCEPT,
      STEP_REJECT
   } step_e;

   function automatic step_e classify(
      input logic [15:0] delta,
      input logic [15:0] max_step
   );
      if (delta == 16'd0)
         return STEP_NONE;
      else if (delta <= max_step)
         return STEP_ACCEPT;
      else
         return STEP_REJECT;
   endfunction

endpackage

// File: rtl/gray_ptr_decoder_g2b.sv
// Combinational Gray-to-binary decode.
// Bit i of the binary value is the XOR of Gray bits N-1 down to i.
module gray_to_binary #(
   parameter int N = 4
) (
   input  logic [N-1:0] gray,
   output logic [N-1:0] bin
);

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign bin[i] = ^gray[N-1:i];
   end

endmodule

// File: rtl/gray_ptr_decoder.sv
// Decodes a synchronized Gray pointer and accumulates its advances
// into a pending-event count drained one event per handshake.
module gray_ptr_decoder
   import gray_ptr_decoder_pkg::*;
#(
   parameter int N       = 4,
   parameter int MaxStep = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   input  logic [N-1:0] gray_i,
   output logic [N-1:0] bin_o,
   output logic         evt_valid_o,
   input  logic         evt_ready_i,
   output logic [N:0]   pending_o,
   output logic         step_err_o,
   output logic         ovf_o,
   input  logic         clear_i
);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("gray_ptr_decoder: N out of range 2..16");
   end
   if (MaxStep < 1 || MaxStep > (1 << N) - 1) begin : g_bad_step
      $error("gray_ptr_decoder: MaxStep out of range");
   end

   localparam logic [N+1:0] PMAX = {2'b00, {(N){1'b1}}} |
                                   (N+2)'(1 << N);

   logic [N-1:0] gray_q;
   logic [N-1:0] bin_new;
   logic [N-1:0] delta;
   logic         changed;
   logic         consume;
   step_e        kind;
   logic [N+1:0] add;
   logic [N+1:0] sum;
   logic         sat;
   logic [N:0]   pending_next;

   gray_to_binary #(.N(N)) u_g2b (
      .gray (gray_i),
      .bin  (bin_new)
   );

   // An unchanged Gray word can only decode to zero advance.
   assign changed = en_i && (gray_i != gray_q);
   assign delta   = changed ? bin_new - bin_o : '0;
   assign kind    = classify(16'(delta), 16'(MaxStep));
   assign consume = evt_valid_o & evt_ready_i;

   assign add = (kind == STEP_ACCEPT) ? {2'b00, delta} : '0;
   assign sum = {1'b0, pending_o} + add - (N+2)'(consume);
   assign sat = sum > PMAX;
   assign pending_next = sat ? PMAX[N:0] : sum[N:0];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         gray_q      <= '0;
         bin_o       <= '0;
         pending_o   <= '0;
         evt_valid_o <= 1'b0;
         step_err_o  <= 1'b0;
         ovf_o       <= 1'b0;
      end else begin
         if (kind != STEP_NONE) begin
            gray_q <= gray_i;
            bin_o  <= bin_new;
         end
         pending_o   <= pending_next;
         evt_valid_o <= (pending_next != '0);
         step_err_o  <= (kind == STEP_REJECT) |
                        (step_err_o & ~clear_i);
         ovf_o       <= sat | (ovf_o & ~clear_i);
      end
   end

endmodule
